// File: rtl/shift_window_pkg.sv
// Shared types and constants for the sliding-window controller and its lane shifter.
package shift_window_pkg;

    localparam int LANES     = 8;
    localparam int LANE_W    = 12;
    localparam int MAX_SHIFT = 5;
    localparam int WIN_W     = LANES * LANE_W;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [WIN_W-1:0]  window_t;
    typedef logic [2:0]        shift_t;

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        EMIT
    } state_t;

endpackage

// File: rtl/shift_window_seq_shift_left.sv
// Combinational lane shifter: moves the window toward the MSB by whole lanes
// and fills the vacated low lanes; out_valid flags a legal shift amount.
module shift_left
    import shift_window_pkg::*;
(
    input  window_t    in,
    input  shift_t     shift,
    input  lane_t      fill,
    output window_t    out,
    output logic       out_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        out_valid = (shift <= shift_t'(MAX_SHIFT));
        out       = in;
        if (out_valid) begin
            out = in << (int'(shift) * LANE_W);
            for (int i = 0; i < LANES; i++) begin
                if (i < int'(shift)) out[i*LANE_W +: LANE_W] = fill;
            end
        end
    end

endmodule

// File: rtl/shift_window_seq.sv
// Sliding-window controller: accepts loads and shift commands, drives the lane
// shifter from the window register and presents snapshots downstream.
module shift_window_seq
    import shift_window_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  window_t       load_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  shift_t        cmd_shift,
    input  lane_t         cmd_fill,
    input  logic          cmd_emit,
    output logic          win_valid,
    input  logic          win_ready,
    output window_t       win_data,
    output logic [3:0]    stale_lanes,
    output logic          err_invalid,
    output logic [7:0]    err_count
);

    state_t     state;
    window_t    shifted;
    logic       shift_ok;
    logic       load_fire;
    logic       cmd_fire;
    logic [4:0] stale_sum;

    shift_left u_shift (
        .in        (win_data),
        .shift     (cmd_shift),
        .fill      (cmd_fill),
        .out       (shifted),
        .out_valid (shift_ok)
    );

    // A pending load always wins over a command in the same cycle.
    assign cmd_ready = (state == ACTIVE) && !load_valid;
    assign load_fire = load_valid && load_ready;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign stale_sum = {1'b0, stale_lanes} + {2'b00, cmd_shift};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the window is a plain register, not a memory, so clearing it on reset is cheap and observable.
            state       <= EMPTY;
            win_data    <= '0;
            stale_lanes <= '0;
            err_count   <= '0;
            err_invalid <= 1'b0;
            win_valid   <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            err_invalid <= 1'b0;
            case (state)
                EMPTY: begin
                    if (load_fire) begin
                        win_data    <= load_data;
                        stale_lanes <= '0;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (load_fire) begin
                        win_data    <= load_data;
                        stale_lanes <= '0;
                    end else if (cmd_fire) begin
                        if (shift_ok) begin
                            win_data    <= shifted;
                            stale_lanes <= (stale_sum > 5'd8) ? 4'd8 : stale_sum[3:0];
                        end else begin
                            err_invalid <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                        if (cmd_emit) begin
                            state      <= EMIT;
                            win_valid  <= 1'b1;
                            load_ready <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        state      <= ACTIVE;
                        win_valid  <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    win_valid  <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
